// File: rtl/hub75_scan_ctrl_if.sv
// Frame-RAM read port and HUB75 panel connector signals of the scan controller.
// master = controller side, slave = frame RAM / panel side.
interface hub75_scan_ctrl_if #(
    parameter int COLS     = 64,
    parameter int ROW_BITS = 5,
    parameter int PLANES   = 4
) ();
    localparam int ADDR_W = ROW_BITS + $clog2(COLS);

    logic [ADDR_W-1:0]   o_rd_addr;
    logic [6*PLANES-1:0] i_rd_data;
    logic                o_clk;
    logic                o_latch;
    logic                o_blank;
    logic [1:0]          o_data_r;
    logic [1:0]          o_data_g;
    logic [1:0]          o_data_b;
    logic [ROW_BITS-1:0] o_row_select;
    logic                o_frame_done;

    modport master (
        output o_rd_addr, o_clk, o_latch, o_blank,
        output o_data_r, o_data_g, o_data_b, o_row_select, o_frame_done,
        input  i_rd_data
    );

    modport slave (
        input  o_rd_addr, o_clk, o_latch, o_blank,
        input  o_data_r, o_data_g, o_data_b, o_row_select, o_frame_done,
        output i_rd_data
    );
endinterface

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan controller with bit-plane modulation; plane p+1 shifts while plane p is lit.
// Optional HUB75_TESTPAT_EN adds i_test_mode, replacing RAM pixels with a generated pattern.
module hub75_scan_ctrl #(
    parameter int COLS      = 64,
    parameter int ROW_BITS  = 5,
    parameter int PLANES    = 4,
    parameter int CLK_DIV   = 2,
    parameter int BASE_TIME = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
`ifdef HUB75_TESTPAT_EN
    input  logic              i_test_mode,
`endif
    hub75_scan_ctrl_if.master hub
);
    localparam int COL_W  = $clog2(COLS);
    localparam int ADDR_W = ROW_BITS + COL_W;
    localparam int PL_W   = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LAT_W  = $clog2(CLK_DIV + 2);
    localparam int DISP_W = $clog2(BASE_TIME) + PLANES;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    logic [1:0]          state_r;
    logic [COL_W-1:0]    col_r;
    logic [DIV_W-1:0]    div_r;
    logic [LAT_W-1:0]    lat_r;
    logic [PL_W-1:0]     plane_r;
    logic [ROW_BITS-1:0] row_r;
    logic [DISP_W-1:0]   disp_r;
    logic                clk_r;
    logic                latch_r;
    logic                blank_r;
    logic [5:0]          pix_r;
    logic [ROW_BITS-1:0] row_sel_r;
    logic [ADDR_W-1:0]   addr_r;
    logic                frame_done_r;

    logic                last_plane_s;
    logic                last_row_s;
    logic                last_col_s;
    logic                div_end_s;
    logic [PL_W-1:0]     next_plane_s;
    logic [ROW_BITS-1:0] next_row_s;
    logic [PL_W-1:0]     load_plane_s;
    logic [ROW_BITS-1:0] load_row_s;
    logic [COL_W-1:0]    load_col_s;
    logic [ADDR_W-1:0]   addr_after_s;
    logic [6*PLANES-1:0] word_s;
    logic [5:0]          pixel_s;

    // Picks bit 'plane' of each of the six colour fields {r1,g1,b1,r0,g0,b0}
    function automatic logic [5:0] plane_bits(input logic [6*PLANES-1:0] word,
                                              input logic [PL_W-1:0] plane);
        logic [5:0] bits;
        for (int f = 0; f < 6; f++) begin
            bits[f] = word[f*PLANES + int'(plane)];
        end
        return bits;
    endfunction

    assign last_plane_s = (plane_r == PL_W'(PLANES - 1));
    assign last_row_s   = (row_r == {ROW_BITS{1'b1}});
    assign last_col_s   = (col_r == COL_W'(COLS - 1));
    assign div_end_s    = (div_r == DIV_W'(CLK_DIV - 1));
    assign next_plane_s = last_plane_s ? PL_W'(0) : plane_r + PL_W'(1);
    assign next_row_s   = last_plane_s ? row_r + ROW_BITS'(1) : row_r;

    // Which pixel the next data load captures: column 0 of the upcoming plane when starting a shift
    always_comb begin
        load_plane_s = plane_r;
        load_row_s   = row_r;
        load_col_s   = col_r + COL_W'(1);
        if (state_r == ST_LATCH) begin
            load_plane_s = next_plane_s;
            load_row_s   = next_row_s;
            load_col_s   = COL_W'(0);
        end else if (state_r == ST_IDLE) begin
            load_col_s   = COL_W'(0);
        end else begin
            load_col_s   = col_r + COL_W'(1);
        end
    end

    // After the last column the RAM pointer is parked on column 0 of the next plane's row (prefetch)
    assign addr_after_s = (load_col_s == COL_W'(COLS - 1)) ? {next_row_s, COL_W'(0)}
                                                           : {load_row_s, load_col_s + COL_W'(1)};

`ifdef HUB75_TESTPAT_EN
    logic [PLANES-1:0] tp_r_s;
    logic [PLANES-1:0] tp_g_s;
    assign tp_r_s = PLANES'(load_col_s);
    assign tp_g_s = PLANES'(load_row_s);
    assign word_s = i_test_mode ? {tp_r_s, tp_g_s, {PLANES{1'b1}}, tp_r_s, tp_g_s, {PLANES{1'b1}}}
                                : hub.i_rd_data;
`else
    assign word_s = hub.i_rd_data;
`endif

    assign pixel_s = plane_bits(word_s, load_plane_s);

    // Scan FSM, shift-clock divider, latch sequencer and display counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= ST_IDLE;
            col_r        <= '0;
            div_r        <= '0;
            lat_r        <= '0;
            plane_r      <= '0;
            row_r        <= '0;
            disp_r       <= '0;
            clk_r        <= 1'b0;
            latch_r      <= 1'b0;
            blank_r      <= 1'b1;
            pix_r        <= 6'd0;
            row_sel_r    <= '0;
            addr_r       <= '0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            if (disp_r != DISP_W'(0)) begin
                disp_r <= disp_r - DISP_W'(1);
                if (disp_r == DISP_W'(1)) begin
                    blank_r <= 1'b1;
                end
            end
            case (state_r)
                ST_IDLE: begin
                    clk_r   <= 1'b0;
                    latch_r <= 1'b0;
                    if (i_enable) begin
                        state_r <= ST_SHIFT;
                        div_r   <= '0;
                        col_r   <= '0;
                        pix_r   <= pixel_s;
                        addr_r  <= addr_after_s;
                    end
                end
                ST_SHIFT: begin
                    if (!div_end_s) begin
                        div_r <= div_r + DIV_W'(1);
                    end else begin
                        div_r <= '0;
                        if (!clk_r) begin
                            clk_r <= 1'b1;
                        end else begin
                            clk_r <= 1'b0;
                            if (last_col_s) begin
                                lat_r   <= '0;
                                state_r <= (disp_r == DISP_W'(0)) ? ST_LATCH : ST_WAIT;
                            end else begin
                                col_r  <= col_r + COL_W'(1);
                                pix_r  <= pixel_s;
                                addr_r <= addr_after_s;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (disp_r == DISP_W'(0)) begin
                        lat_r   <= '0;
                        state_r <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    lat_r <= lat_r + LAT_W'(1);
                    if (lat_r == LAT_W'(0)) begin
                        latch_r <= 1'b1;
                        if (plane_r == PL_W'(0)) begin
                            row_sel_r <= row_r;
                        end
                    end else if (lat_r == LAT_W'(CLK_DIV)) begin
                        latch_r <= 1'b0;
                    end else if (lat_r == LAT_W'(CLK_DIV + 1)) begin
                        blank_r      <= 1'b0;
                        disp_r       <= DISP_W'(BASE_TIME) << plane_r;
                        plane_r      <= next_plane_s;
                        row_r        <= next_row_s;
                        frame_done_r <= last_row_s && last_plane_s;
                        if (last_row_s && last_plane_s && !i_enable) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_SHIFT;
                            div_r   <= '0;
                            col_r   <= '0;
                            pix_r   <= pixel_s;
                            addr_r  <= addr_after_s;
                        end
                    end else begin
                        latch_r <= latch_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign hub.o_rd_addr    = addr_r;
    assign hub.o_clk        = clk_r;
    assign hub.o_latch      = latch_r;
    assign hub.o_blank      = blank_r;
    assign hub.o_data_r     = {pix_r[5], pix_r[2]};
    assign hub.o_data_g     = {pix_r[4], pix_r[1]};
    assign hub.o_data_b     = {pix_r[3], pix_r[0]};
    assign hub.o_row_select = row_sel_r;
    assign hub.o_frame_done = frame_done_r;
endmodule
